// File: rtl/deformator_9.sv
// deformator_9: output de-skew collector for the 9x9 systolic array.
// Realigns 9 diagonally skewed lanes into rows and queues them in a FIFO.
//
// Ports:
//   clk, reset        clock, async active-low reset
//   in, in_valid      skewed lanes (lane i lags lane 0 by i cycles)
//   out, out_valid    aligned row at FIFO head, FIFO non-empty
//   out_ready         downstream accept
//   frame_done        1-cycle pulse after ROWS accepted rows
//   overflow          sticky drop flag, ovf_clr clears it
//   fill_level        FIFO occupancy (only with DEFORMATOR_STATUS_EN)
module deformator_9 #(
  parameter int int_bits = 13,
  parameter int DEPTH    = 4,
  parameter int ROWS     = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [int_bits*9-1:0] in,
  input  logic                  in_valid,
  output logic [int_bits*9-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef DEFORMATOR_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0] fill_level
`endif
);

  localparam int W  = int_bits;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ROWS + 1);

  logic [W*9-1:0] aligned;
  logic [7:0]     vpipe;
  logic           aligned_valid;

  // Lane i gets 8-i delay stages so all lanes line up with lane 8.
  for (genvar i = 0; i < 9; i++) begin : g_lane
    if (i == 8) begin : g_direct
      assign aligned[i*W +: W] = in[i*W +: W];
    end else begin : g_dly
      logic [W-1:0] pipe [8-i];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < 8 - i; k++)
            pipe[k] <= '0;
        end else begin
          pipe[0] <= in[i*W +: W];
          for (int k = 1; k < 8 - i; k++)
            pipe[k] <= pipe[k-1];
        end
      end

      assign aligned[i*W +: W] = pipe[7-i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vpipe <= '0;
    else        vpipe <= {vpipe[6:0], in_valid};
  end

  assign aligned_valid = vpipe[7];

  logic [W*9-1:0] mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    count;
  logic [AW:0]    count_nxt;
  logic           full;
  logic           pop;
  logic           wr;
  logic           drop;

  assign out_valid = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr        = aligned_valid & (~full | pop);
  assign drop      = aligned_valid & full & ~pop;
  assign out       = out_valid ? mem[rptr] : '0;

  always_comb begin
    count_nxt = count;
    if (wr)  count_nxt = count_nxt + 1'b1;
    if (pop) count_nxt = count_nxt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= aligned;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count_nxt;
    end
  end

  logic [CW-1:0] rows_q;
  logic          last_row;

  assign last_row = (rows_q == CW'(ROWS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop & last_row;
      if (pop) rows_q <= last_row ? '0 : rows_q + 1'b1;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

`ifdef DEFORMATOR_STATUS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fill_level <= '0;
    else        fill_level <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_deformator_9.sv
// tb_deformator_9: scoreboard bench for deformator_9.
// Directed skewed rows; monitor pops expected rows on each accept.
module tb_deformator_9;

  localparam int W  = 13;
  localparam int RW = 9 * W;
  localparam int NC = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] in;
  logic          in_valid;
  logic [RW-1:0] out;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          overflow;
  logic          ovf_clr;
`ifdef DEFORMATOR_STATUS_EN
  logic [2:0]    fill_level;
`endif

  always #5 clk = ~clk;

  deformator_9 #(
    .int_bits(W),
    .DEPTH(4),
    .ROWS(9)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .in_valid(in_valid),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef DEFORMATOR_STATUS_EN
    ,
    .fill_level(fill_level)
`endif
  );

  typedef struct {
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++)
      r[i*W +: W] = W'(base + i);
    return r;
  endfunction

  function automatic logic [NC-1:0] rng(input int a, input int b);
    logic [NC-1:0] v;
    v = '0;
    for (int i = a; i <= b; i++)
      v[i] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] s_lane [NC][9];
  bit           s_v   [NC];
  bit           s_rdy [NC];
  bit           s_clr [NC];
  bit           s_rst [NC];

  bit            mon_on = 1'b0;
  int            rel = -1;
  logic [NC-1:0] tr_ov;
  logic [NC-1:0] tr_fd;
  logic [NC-1:0] tr_of;
  int            fl [NC];
  logic [RW-1:0] prev_out;
  bit            prev_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_on && rel >= 0 && rel < NC) begin
      tr_ov[rel] = out_valid;
      tr_fd[rel] = frame_done;
      tr_of[rel] = overflow;
`ifdef DEFORMATOR_STATUS_EN
      fl[rel] = int'(fill_level);
`endif
    end
    if (prev_hold && out_valid)
      check("hold_stable", out, prev_out);
    prev_hold = out_valid && !out_ready && reset;
    prev_out  = out;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_row: got %0h at cycle %0d expected none",
                 out, rel);
      end else begin
        e = sb.pop_front();
        check("row_data", out, e.data);
        if (e.cyc >= 0)
          check("row_cycle", rel, e.cyc);
      end
    end
  end

  task automatic clear_sched();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < 9; i++)
        s_lane[c][i] = '0;
      s_v[c]   = 1'b0;
      s_rdy[c] = 1'b0;
      s_clr[c] = 1'b0;
      s_rst[c] = 1'b0;
      fl[c]    = 0;
    end
    tr_ov = '0;
    tr_fd = '0;
    tr_of = '0;
  endtask

  // ecyc >= 0: expected accept cycle; -1: any cycle; -2: row is discarded
  task automatic add_row(input int t, input int base, input int ecyc);
    exp_t x;
    s_v[t] = 1'b1;
    for (int i = 0; i < 9; i++)
      if (t + i < NC)
        s_lane[t+i][i] = W'(base + i);
    if (ecyc != -2) begin
      x.data = mkrow(base);
      x.cyc  = ecyc;
      sb.push_back(x);
    end
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in        = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    mon_on = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rel       = c;
      reset     = s_rst[c] ? 1'b0 : 1'b1;
      in_valid  = s_v[c];
      for (int i = 0; i < 9; i++)
        in[i*W +: W] = s_lane[c][i];
      out_ready = s_rdy[c];
      ovf_clr   = s_clr[c];
    end
    @(negedge clk);
    #1;
    mon_on = 1'b0;
    rel    = -1;
    idle();
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);

    // single row
    do_reset();
    clear_sched();
    add_row(0, 100, 9);
    for (int c = 0; c < NC; c++) s_rdy[c] = 1'b1;
    run(16);
    check("s1_out_valid", tr_ov, rng(9, 9));
    check("s1_frame_done", tr_fd, 0);

    // back-to-back full frame
    do_reset();
    clear_sched();
    for (int r = 0; r < 9; r++) add_row(r, 16 * r, 9 + r);
    for (int c = 0; c < NC; c++) s_rdy[c] = 1'b1;
    run(24);
    check("s2_out_valid", tr_ov, rng(9, 17));
    check("s2_frame_done", tr_fd, rng(18, 18));

    // backpressure with one dropped row
    do_reset();
    clear_sched();
    for (int r = 0; r < 4; r++) add_row(1 + r, 1000 + 16 * r, 16 + r);
    add_row(5, 1064, -2);
    for (int c = 16; c < NC; c++) s_rdy[c] = 1'b1;
    s_clr[21] = 1'b1;
    run(26);
    check("s3_out_valid", tr_ov, rng(10, 19));
    check("s3_overflow", tr_of, rng(14, 21));
    check("s3_frame_done", tr_fd, 0);

    // full FIFO with simultaneous pop
    do_reset();
    clear_sched();
    for (int r = 0; r < 5; r++) add_row(1 + r, 2000 + 16 * r, 13 + r);
    for (int c = 13; c < NC; c++) s_rdy[c] = 1'b1;
    run(22);
    check("s4_out_valid", tr_ov, rng(10, 17));
    check("s4_overflow", tr_of, 0);

    // reset in the middle of a row
    do_reset();
    clear_sched();
    add_row(0, 3000, -2);
    add_row(7, 3100, 16);
    s_rst[4] = 1'b1;
    s_rst[5] = 1'b1;
    for (int c = 0; c < NC; c++) s_rdy[c] = 1'b1;
    run(20);
    check("s5_out_valid", tr_ov, rng(16, 16));
    check("s5_overflow", tr_of, 0);

    // occupancy walk
    do_reset();
    clear_sched();
    add_row(0, 4000, 12);
    add_row(1, 4016, 15);
    add_row(2, 4032, 16);
    s_rdy[12] = 1'b1;
    for (int c = 15; c < NC; c++) s_rdy[c] = 1'b1;
    run(22);
    check("s6_out_valid", tr_ov, rng(9, 16));
`ifdef DEFORMATOR_STATUS_EN
    check("s6_fill_c9", fl[9], 1);
    check("s6_fill_c10", fl[10], 2);
    check("s6_fill_c11", fl[11], 3);
    check("s6_fill_c13", fl[13], 2);
    check("s6_fill_c17", fl[17], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/deformator_9.md
Name: deformator_9

Overview:
- Output-side de-skew collector for the 9x9 systolic datapath; it is the inverse of the input skewing formator.
- Takes 9 lanes whose words arrive diagonally skewed (lane i lags lane 0 by i cycles) and realigns them into one row vector per cycle.
- Buffers realigned rows in a small FIFO and hands them downstream with valid/ready.
- Counts delivered rows per frame and flags frame completion and overflow.

Parameters:
- int_bits, 13, width of each lane word.
- DEPTH, 4, FIFO depth in rows; power of 2, minimum 2.
- ROWS, 9, rows per frame for frame_done generation; minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  int_bits*9  skewed lane data; lane i is in[i*int_bits +: int_bits].
- in_valid  input  1  qualifies the lane-0 word of a row; lane i of the same row is sampled i cycles later.
- out  output  int_bits*9  aligned row at the FIFO head; lane i is out[i*int_bits +: int_bits].
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts out when out_valid and out_ready are both high.
- frame_done  output  1  one-cycle pulse after the ROWS-th accepted row.
- overflow  output  1  sticky; set when an aligned row is dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset low, async) clears:
  - all deskew stages, the valid pipe, FIFO read/write pointers and count, the row counter, and the frame_done and overflow registers;
  - outputs go to out_valid=0, out=0, frame_done=0, overflow=0.
  - Rows partially inside the deskew pipe are discarded. Operation resumes on the first edge after reset deasserts.
- Deskew:
  - lane i passes through 8-i registers (lane 0: 8, lane 8: 0);
  - in_valid passes through 8 registers, giving aligned_valid.
  - A row whose lane-0 word is presented with in_valid in cycle T forms an aligned row in cycle T+8.
  - Lane 8 is sampled directly from in in cycle T+8.
- Push: when aligned_valid is high, the aligned row is written into the FIFO on the edge ending cycle T+8.
- Latency: with an empty FIFO, out_valid rises in cycle T+9 and out shows the row. There is no fall-through.
- Pop: occurs on an edge where out_valid and out_ready are both high; the head advances and out shows the next row in the following cycle.
- out holds stable while out_valid is high and out_ready is low.
- Full, push with no pop: the row is dropped, FIFO contents are unchanged, and overflow is set from the next cycle.
- Full, push and pop in the same cycle: both take effect, count is unchanged, and no overflow.
- Empty, push and pop in the same cycle: no pop can occur since out_valid=0; the push proceeds.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Frame counter:
  - counts pops from 0 to ROWS-1;
  - on the pop that completes ROWS, the counter wraps to 0 and frame_done is high for exactly the next cycle.
- overflow:
  - cleared by ovf_clr on the next edge;
  - if ovf_clr and a drop occur in the same cycle, set wins.
- Data is passed unmodified; there is no arithmetic on lane words.
- in_valid may be high on consecutive cycles; the sustained throughput is 1 row/cycle while out_ready is high.

Optional Feature:
- DEFORMATOR_STATUS_EN: when defined, adds output port fill_level (log2(DEPTH)+1 bits).
  - It is a registered copy of the FIFO count, and reset value is 0.
  - It updates on the same edge as push/pop, so it equals the number of rows held.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Single row: in_valid=1 at T=0; lane i holds value 100+i in cycle i; out_ready=1 -> out_valid=1 only in cycle 9, out lanes = 100..108, then out_valid=0.
- Back-to-back: 9 rows on consecutive cycles, row r lane i = 16*r+i, out_ready=1 -> out_valid high in cycles 9..17, rows in order, frame_done=1 in cycle 18 only.
- Backpressure/overflow: out_ready=0, DEPTH=4, 5 rows on consecutive cycles -> rows 0..3 held, row 4 dropped, overflow=1 from cycle 14; then out_ready=1 -> rows 0..3 delivered, ovf_clr pulse -> overflow=0 next cycle.
- Full with simultaneous pop: FIFO holds 4 rows, out_ready=1 in the same cycle a 5th row aligns -> 5 rows delivered in order, overflow stays 0.
- Mid-operation reset: reset low in cycle 4 after a row starts at T=0, release in cycle 6 -> out_valid never rises for that row, overflow=0, a new row started at cycle 7 appears at cycle 16.
- With DEFORMATOR_STATUS_EN: 3 rows, out_ready=0 -> fill_level reads 1,2,3 in cycles 9,10,11; one pop -> 2.
